// File: rtl/adc_seq_ctrl_if.sv
// Bundle of the SAR conversion sequencer's request inputs and phase/status outputs.
// master: the side that requests conversions; slave: the sequencer itself.
interface adc_seq_ctrl_if;
    logic       start;
    logic       abort;
    logic       seq_init;
    logic       seq_samp;
    logic       seq_comp;
    logic       seq_update;
    logic [3:0] bit_idx;
    logic       busy;
    logic       done;

    modport master (
        output start, abort,
        input  seq_init, seq_samp, seq_comp, seq_update, bit_idx, busy, done
    );

    modport slave (
        input  start, abort,
        output seq_init, seq_samp, seq_comp, seq_update, bit_idx, busy, done
    );
endinterface

// File: rtl/adc_seq_ctrl.sv
// SAR ADC conversion sequencer: init, sample, NBITS compare/update pairs, done pulse.
// Define ADC_SEQ_BACK2BACK_EN to let DONE chain straight into the next INIT while start is held.
//
//   state  | meaning
//   -------+--------------------------------------------------
//   IDLE   | waiting for start
//   INIT   | DAC initialization, INIT_CYC cycles
//   SAMP   | input sampling, SAMP_CYC cycles
//   COMP   | comparator decision for bit bit_idx
//   UPDATE | DAC update for bit bit_idx
//   DONE   | one-cycle end-of-conversion pulse
module adc_seq_ctrl #(
    parameter int NBITS    = 8,
    parameter int INIT_CYC = 1,
    parameter int SAMP_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    adc_seq_ctrl_if.slave bus
);

    if (NBITS < 1 || NBITS > 16) begin : g_bad_nbits
        $error("adc_seq_ctrl: NBITS must be in 1..16");
    end
    if (INIT_CYC < 1 || INIT_CYC > 15) begin : g_bad_init
        $error("adc_seq_ctrl: INIT_CYC must be in 1..15");
    end
    if (SAMP_CYC < 1 || SAMP_CYC > 15) begin : g_bad_samp
        $error("adc_seq_ctrl: SAMP_CYC must be in 1..15");
    end

    // One-hot so each phase output is a bare flop with no decode behind it.
    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_INIT   = 6'b000010,
        S_SAMP   = 6'b000100,
        S_COMP   = 6'b001000,
        S_UPDATE = 6'b010000,
        S_DONE   = 6'b100000
    } state_t;

    localparam int B_INIT   = 1;
    localparam int B_SAMP   = 2;
    localparam int B_COMP   = 3;
    localparam int B_UPDATE = 4;
    localparam int B_DONE   = 5;

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYC - 1);
    localparam logic [3:0] SAMP_LAST = 4'(SAMP_CYC - 1);
    localparam logic [3:0] BIT_TOP   = 4'(NBITS - 1);

    state_t     state_q, state_nxt;
    logic [3:0] cnt_q, cnt_nxt;
    logic [3:0] bit_q, bit_nxt;
    logic       busy_q, busy_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            bit_q   <= bit_nxt;
            busy_q  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        bit_nxt   = bit_q;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;

        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (bus.start) state_nxt = S_INIT;
                S_INIT:   if (cnt_q == INIT_LAST) state_nxt = S_SAMP;
                S_SAMP: begin
                    if (cnt_q == SAMP_LAST) begin
                        state_nxt = S_COMP;
                        bit_nxt   = BIT_TOP;
                    end
                end
                S_COMP:   state_nxt = S_UPDATE;
                S_UPDATE: begin
                    if (bit_q != 4'd0) begin
                        state_nxt = S_COMP;
                        bit_nxt   = bit_q - 4'd1;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
`ifdef ADC_SEQ_BACK2BACK_EN
                S_DONE:   state_nxt = bus.start ? S_INIT : S_IDLE;
`else
                S_DONE:   state_nxt = S_IDLE;
`endif
                default:  state_nxt = S_IDLE;
            endcase
        end

        if (state_nxt == S_IDLE) bit_nxt = '0;

        // Counter restarts on every state entry and only advances in the timed phases.
        if (state_nxt == state_q && (state_q == S_INIT || state_q == S_SAMP))
            cnt_nxt = cnt_q + 4'd1;

        busy_nxt = (state_nxt != S_IDLE);
    end

    assign bus.seq_init   = state_q[B_INIT];
    assign bus.seq_samp   = state_q[B_SAMP];
    assign bus.seq_comp   = state_q[B_COMP];
    assign bus.seq_update = state_q[B_UPDATE];
    assign bus.done       = state_q[B_DONE];
    assign bus.bit_idx    = bit_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: directed timing scenarios plus a randomized run checked
// against a conversion-position model of the sequence.
module tb_adc_seq_ctrl;

    localparam int NB = 8;
    localparam int IC = 1;
    localparam int SC = 2;
    localparam int LEN = IC + SC + 2 * NB + 1;
`ifdef ADC_SEQ_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_seq_ctrl_if bus ();
    adc_seq_ctrl_if sbus ();

    adc_seq_ctrl #(.NBITS(NB), .INIT_CYC(IC), .SAMP_CYC(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    adc_seq_ctrl #(.NBITS(1), .INIT_CYC(3), .SAMP_CYC(1)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pos   = 0;   // model: 0 idle, 1..LEN position within a conversion

    logic [5:0] dut_v, sml_v;
    assign dut_v = {bus.seq_init, bus.seq_samp, bus.seq_comp, bus.seq_update, bus.busy, bus.done};
    assign sml_v = {sbus.seq_init, sbus.seq_samp, sbus.seq_comp, sbus.seq_update, sbus.busy, sbus.done};

    // {init, samp, comp, update, busy, done} expected at conversion position p
    function automatic logic [5:0] exp_vec(int p);
        logic [5:0] v = '0;
        if (p == 0) return v;
        if (p <= IC)            v[5] = 1'b1;
        else if (p <= IC + SC)  v[4] = 1'b1;
        else if (p < LEN) begin
            if (((p - IC - SC - 1) % 2) == 0) v[3] = 1'b1;
            else                              v[2] = 1'b1;
        end else                v[0] = 1'b1;
        v[1] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] exp_bit(int p);
        return 4'(NB - 1 - (p - IC - SC - 1) / 2);
    endfunction

    // Drive inputs for the coming edge, advance the model, land on the next falling edge.
    task automatic cycle(input logic s, input logic a);
        bus.start = s;
        bus.abort = a;
        @(posedge clk);
        if (a)              pos = 0;
        else if (pos == 0)  pos = s ? 1 : 0;
        else if (pos == LEN) pos = (B2B && s) ? 1 : 0;
        else                pos = pos + 1;
        @(negedge clk);
    endtask

    task automatic go_idle();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        sbus.start = 1'b0; sbus.abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut_v !== 6'b0 || bus.bit_idx !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_main got %b/%0d want 000000/0", dut_v, bus.bit_idx);
        end
        n_cmp++;
        if (sml_v !== 6'b0 || sbus.bit_idx !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_small got %b/%0d want 000000/0", sml_v, sbus.bit_idx);
        end
        rst_n = 1'b1;
        pos = 0;
        cycle(1'b0, 1'b0);
        n_cmp++;
        if (dut_v !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_idle got %b want 000000", dut_v);
        end
    endtask

    task automatic test_default_conversion();
        logic [5:0] e;
        go_idle();
        for (int c = 1; c <= 21; c++) begin
            cycle(c == 1, 1'b0);
            e[5] = (c == 1);
            e[4] = (c >= 2 && c <= 3);
            e[3] = (c >= 4 && c <= 18 && c % 2 == 0);
            e[2] = (c >= 5 && c <= 19 && c % 2 == 1);
            e[1] = (c >= 1 && c <= 20);
            e[0] = (c == 20);
            n_cmp++;
            if (dut_v !== e) begin
                n_bad++;
                $display("FAIL default_phase c=%0d got %b want %b", c, dut_v, e);
            end
            if (c >= 4 && c <= 19) begin
                n_cmp++;
                if (bus.bit_idx !== 4'(7 - (c - 4) / 2)) begin
                    n_bad++;
                    $display("FAIL default_bit c=%0d got %0d want %0d", c, bus.bit_idx, 7 - (c - 4) / 2);
                end
            end
        end
    endtask

    task automatic test_abort();
        int done_seen = 0;
        int done_at = -1;
        go_idle();
        cycle(1'b1, 1'b0);                           // edge 0
        for (int c = 1; c <= 9; c++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);                           // edge 10
        n_cmp++;
        if (dut_v !== 6'b0 || bus.bit_idx !== 4'd0) begin
            n_bad++;
            $display("FAIL abort_clear got %b/%0d want 000000/0", dut_v, bus.bit_idx);
        end
        cycle(1'b0, 1'b0);                           // edge 11
        if (bus.done) done_seen++;
        cycle(1'b1, 1'b0);                           // edge 12, fresh start
        for (int k = 1; k <= 21; k++) begin
            if (k > 1) cycle(1'b0, 1'b0);
            if (bus.done && done_at < 0) done_at = k;
            n_cmp++;
            if (dut_v !== exp_vec(pos)) begin
                n_bad++;
                $display("FAIL abort_restart k=%0d got %b want %b", k, dut_v, exp_vec(pos));
            end
        end
        n_cmp++;
        if (done_seen != 0 || done_at != LEN) begin
            n_bad++;
            $display("FAIL abort_done got early=%0d at=%0d want early=0 at=%0d", done_seen, done_at, LEN);
        end
    endtask

    task automatic test_start_held();
        int busy_low = 0;
        logic e_done;
        go_idle();
        for (int c = 1; c <= 63; c++) begin
            cycle(1'b1, 1'b0);
            e_done = B2B ? (c % 20 == 0 && c <= 60) : (c % 21 == 20);
            n_cmp++;
            if (bus.done !== e_done) begin
                n_bad++;
                $display("FAIL held_done c=%0d got %b want %b", c, bus.done, e_done);
            end
            n_cmp++;
            if (dut_v !== exp_vec(pos)) begin
                n_bad++;
                $display("FAIL held_phase c=%0d got %b want %b", c, dut_v, exp_vec(pos));
            end
            if (c <= 62 && !bus.busy) busy_low++;
        end
        n_cmp++;
        if (busy_low != (B2B ? 0 : 2)) begin
            n_bad++;
            $display("FAIL held_busy_low got %0d want %0d", busy_low, B2B ? 0 : 2);
        end
        go_idle();
    endtask

    task automatic test_small_params();
        logic [5:0] e;
        go_idle();
        for (int c = 1; c <= 8; c++) begin
            sbus.start = (c == 1);
            cycle(1'b0, 1'b0);
            e[5] = (c >= 1 && c <= 3);
            e[4] = (c == 4);
            e[3] = (c == 5);
            e[2] = (c == 6);
            e[1] = (c >= 1 && c <= 7);
            e[0] = (c == 7);
            n_cmp++;
            if (sml_v !== e) begin
                n_bad++;
                $display("FAIL small_phase c=%0d got %b want %b", c, sml_v, e);
            end
            if (c == 5 || c == 6) begin
                n_cmp++;
                if (sbus.bit_idx !== 4'd0) begin
                    n_bad++;
                    $display("FAIL small_bit c=%0d got %0d want 0", c, sbus.bit_idx);
                end
            end
        end
        sbus.start = 1'b0;
    endtask

    task automatic test_async_reset();
        go_idle();
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);                           // now in cycle 2, SAMP
        n_cmp++;
        if (bus.seq_samp !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_pre got samp=%b want 1", bus.seq_samp);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_v !== 6'b0 || bus.bit_idx !== 4'd0) begin
            n_bad++;
            $display("FAIL arst_clear got %b/%0d want 000000/0", dut_v, bus.bit_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pos = 0;
        cycle(1'b1, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            if (k > 1) cycle(1'b0, 1'b0);
            n_cmp++;
            if (dut_v !== exp_vec(pos)) begin
                n_bad++;
                $display("FAIL arst_conv k=%0d got %b want %b", k, dut_v, exp_vec(pos));
            end
        end
    endtask

    task automatic test_random();
        int pairs = 0;
        logic s, a;
        go_idle();
        for (int i = 0; i < 10000; i++) begin
            s = ($urandom_range(3) == 0);
            a = ($urandom_range(40) == 0);
            cycle(s, a);
            n_cmp++;
            if (dut_v !== exp_vec(pos)) begin
                n_bad++;
                $display("FAIL rand_phase i=%0d got %b want %b", i, dut_v, exp_vec(pos));
            end
            if (pos > IC + SC && pos < LEN) begin
                n_cmp++;
                if (bus.bit_idx !== exp_bit(pos)) begin
                    n_bad++;
                    $display("FAIL rand_bit i=%0d got %0d want %0d", i, bus.bit_idx, exp_bit(pos));
                end
            end
            n_cmp++;
            if ($countones(dut_v[5:2]) > 1) begin
                n_bad++;
                $display("FAIL rand_onehot i=%0d got %b want at most one phase", i, dut_v[5:2]);
            end
            if (bus.seq_init) pairs = 0;
            if (bus.seq_update) pairs++;
            if (bus.done) begin
                n_cmp++;
                if (pairs != NB) begin
                    n_bad++;
                    $display("FAIL rand_pairs i=%0d got %0d want %0d", i, pairs, NB);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_conversion();
        test_abort();
        test_start_held();
        test_small_params();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_seq_ctrl.md
# adc_seq_ctrl

Conversion sequencer for the SAR ADC. It generates the four phase signals (`seq_init`, `seq_samp`, `seq_comp`, `seq_update`) that feed the clock-gate stage, where they are ANDed with per-side enables. One conversion is an init phase, a sample phase, then NBITS compare/update pairs, closed by a one-cycle done pulse. All phase outputs are glitch-free registered levels because downstream they become gated clocks.

## Interface
- `NBITS`, 8: bit cycles per conversion; legal range 1..16.
- `INIT_CYC`, 1: cycles `seq_init` is held high; legal range 1..15.
- `SAMP_CYC`, 2: cycles `seq_samp` is held high; legal range 1..15.

- `clk`  in  1  sequencer clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request for a conversion; sampled in IDLE.
- `abort`  in  1  synchronous abort; wins over everything except reset.
- `seq_init`  out  1  DAC initialization phase.
- `seq_samp`  out  1  sampling phase.
- `seq_comp`  out  1  comparator phase.
- `seq_update`  out  1  DAC update phase.
- `bit_idx`  out  4  current bit, NBITS-1 down to 0; valid during COMP/UPDATE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of conversion.

## Operation
- States: IDLE, INIT, SAMP, COMP, UPDATE, DONE. The state register is one-hot. Each `seq_*` is a direct flop output equal to its state bit, with no decode logic after the flop.
- Transitions:
  - IDLE to INIT when `start`=1.
  - INIT to SAMP after INIT_CYC cycles.
  - SAMP to COMP after SAMP_CYC cycles.
  - COMP to UPDATE always after 1 cycle.
  - UPDATE to COMP when `bit_idx`>0, decrementing `bit_idx`.
  - UPDATE to DONE when `bit_idx`=0.
  - DONE to IDLE, except as changed by the macro in Configuration.
- `bit_idx` loads NBITS-1 on entry to COMP from SAMP. It decrements only on the UPDATE-to-COMP transition and never wraps below 0.
- Phase counter: 4 bits, cleared on every state entry, counts cycles within INIT and SAMP.
- At most one `seq_*` is high in any cycle. There is no overlap and no gap between consecutive phases.
- `abort`=1 in any state: next state is IDLE and all outputs go low next cycle. `done` does not fire. `abort` and `start` high together in IDLE: stay in IDLE.
- `start` outside IDLE and DONE is ignored. No queuing.
- Reset: state IDLE; all `seq_*`, `busy`, `done` = 0; `bit_idx` = 0; counter = 0. Reset asserted mid-conversion clears outputs immediately, asynchronously. Deassertion is assumed synchronized upstream.
- Illegal parameters: elaboration-time error via generate-time check.

## Timing
- `start` sampled high at edge 0 gives:
  - `seq_init` high cycles 1..INIT_CYC.
  - `seq_samp` high for the next SAMP_CYC cycles.
  - Alternating `seq_comp` and `seq_update` for 2*NBITS cycles.
  - `done` high for 1 cycle.
- Conversion length from the start edge to the `done` cycle, inclusive: INIT_CYC+SAMP_CYC+2*NBITS+1. Defaults: 20 cycles, `done` in cycle 20.
- `busy` rises together with `seq_init` and falls the cycle after `done`, or directly into the next conversion per Configuration.
- Output-to-output skew is a single flop clock-to-Q. No combinational path from inputs to outputs.

## Configuration
- `ADC_SEQ_BACK2BACK_EN` defined: in DONE with `start`=1 (and `abort`=0), the next state is INIT. Back-to-back conversions run with zero idle cycles, and `busy` stays high continuously.
- Not defined: DONE always goes to IDLE. `start` held high therefore gives exactly one IDLE cycle between conversions, a period of conversion length + 1.

## Test plan
- Reset with defaults, single `start` pulse at edge 0:
  - `seq_init` high cycle 1.
  - `seq_samp` high cycles 2–3.
  - `seq_comp` high on cycles 4, 6, …, 18; `seq_update` high on 5, 7, …, 19.
  - `bit_idx` 7 down to 0.
  - `done` high cycle 20, then `busy` low cycle 21.
- Phase exclusivity: random `start`/`abort` for 10k cycles; assert at most one `seq_*` high every cycle, and `done` only after a full 8 compare/update pairs.
- `abort` on cycle 10 (mid-COMP/UPDATE): all outputs 0 from cycle 11, no `done`. New `start` at cycle 12 gives a full 20-cycle conversion.
- `start` held high, macro undefined: `done` pulses at cycles 20, 41, 62 with one idle cycle between. Macro defined: `done` at 20, 40, 60, with `busy` never low.
- NBITS=1, INIT_CYC=3, SAMP_CYC=1: init cycles 1–3, samp cycle 4, comp 5, update 6, done 7.
- `rst_n` asserted asynchronously mid-SAMP: all outputs 0 before the next clock edge. After release, IDLE, with `start` giving normal timing.
